// File: rtl/pipe_ctrl_pkg.sv
// Shared configuration for pipe_ctrl: pipeline-register mask bit positions, widths, NOP encoding.
// Optional stall performance counter is enabled by defining PIPE_CTRL_PERF_EN.
`ifndef PIPE_CTRL_DEFINES_VH
`define PIPE_CTRL_DEFINES_VH
`define NUM_PIPE_MASKS 4
`define PIPE_REG_PC    0
`define PIPE_REG_IF_ID 1
`define PIPE_REG_ID_EX 2
`define ADDR_WIDTH     8
`define OP_CODE_NOP    32'h0000_0013
`endif

package pipe_ctrl_pkg;
    localparam int          NUM_LANES  = 2;
    localparam int          ADDR_W     = `ADDR_WIDTH;
    localparam int          MASK_W     = `NUM_PIPE_MASKS;
    localparam int          REG_PC     = `PIPE_REG_PC;
    localparam int          REG_IF_ID  = `PIPE_REG_IF_ID;
    localparam int          REG_ID_EX  = `PIPE_REG_ID_EX;
    localparam logic [31:0] NOP        = `OP_CODE_NOP;

    typedef enum logic [1:0] {
        LANE_LOAD  = 2'd0,
        LANE_HOLD  = 2'd1,
        LANE_CLEAR = 2'd2
    } lane_op_e;

    typedef struct packed {
        logic [31:0] instr;
        logic        valid;
    } lane_t;
endpackage

// File: rtl/if_id_lane.sv
// One IF/ID lane register: load, hold, or clear to an invalid NOP.
module if_id_lane
    import pipe_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  lane_op_e op,
    input  lane_t    load_data,
    output lane_t    q
);
    always_ff @(posedge clk) begin
        if (reset) begin
            q.instr <= NOP;
            q.valid <= 1'b0;
        end else begin
            case (op)
                LANE_LOAD:  q <= load_data;
                LANE_CLEAR: begin
                    q.instr <= NOP;
                    q.valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/pipe_ctrl.sv
// Dual-issue front-end control: pair PC, two IF/ID lanes, ID/EX bubble decode, lane-age tracking.
// Define PIPE_CTRL_PERF_EN to add the saturating stall_cycles counter port.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [MASK_W-1:0] stall0,
    input  logic [MASK_W-1:0] stall1,
    input  logic [MASK_W-1:0] nop0,
    input  logic [MASK_W-1:0] nop1,
    input  logic              flush0,
    input  logic              flush1,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [31:0]       fetch_instr0,
    input  logic [31:0]       fetch_instr1,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       if_id_instr0,
    output logic [31:0]       if_id_instr1,
    output logic              if_id_valid0,
    output logic              if_id_valid1,
    output logic              id_ex_bubble0,
    output logic              id_ex_bubble1,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]       stall_cycles,
`endif
    output logic              first
);
    logic [NUM_LANES-1:0][MASK_W-1:0] stall_v, nop_v;
    logic [NUM_LANES-1:0][31:0]       fetch_v;
    logic [NUM_LANES-1:0]             flush_v, bubble_v;
    lane_op_e                         op    [NUM_LANES];
    lane_t                            lane_q[NUM_LANES];
    logic                             pc_hold;
    logic                             skip0;
    logic                             unused_mask_bits;

    assign stall_v = {stall1, stall0};
    assign nop_v   = {nop1, nop0};
    assign fetch_v = {fetch_instr1, fetch_instr0};
    assign flush_v = {flush1, flush0};
    assign pc_hold = stall0[REG_PC] | stall1[REG_PC];
    assign unused_mask_bits = ^{stall0, stall1, nop0, nop1};

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        lane_t load_data;
        assign op[k] = (branch_taken || flush_v[k]) ? LANE_CLEAR :
                       stall_v[k][REG_IF_ID]        ? LANE_HOLD  : LANE_LOAD;
        // The even slot of an odd redirect target lies before the target and must not issue.
        assign load_data.instr = fetch_v[k];
        assign load_data.valid = (k == 0) ? ~skip0 : 1'b1;
        assign bubble_v[k] = branch_taken | nop_v[k][REG_ID_EX] | ~lane_q[k].valid;

        if_id_lane u_lane (
            .clk       (clk),
            .reset     (reset),
            .op        (op[k]),
            .load_data (load_data),
            .q         (lane_q[k])
        );
    end

    assign if_id_instr0  = lane_q[0].instr;
    assign if_id_instr1  = lane_q[1].instr;
    assign if_id_valid0  = lane_q[0].valid;
    assign if_id_valid1  = lane_q[1].valid;
    assign id_ex_bubble0 = bubble_v[0];
    assign id_ex_bubble1 = bubble_v[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= '0;
            first <= 1'b1;
            skip0 <= 1'b0;
        end else if (branch_taken) begin
            pc    <= branch_target;
            first <= ~branch_target[0];
            skip0 <= branch_target[0];
        end else begin
            if (!pc_hold)
                pc <= pc + ADDR_W'(2);
            if (op[0] == LANE_LOAD && op[1] == LANE_LOAD)
                first <= ~pc[0];
            if (op[0] == LANE_LOAD)
                skip0 <= 1'b0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= '0;
        else if (pc_hold && !branch_taken && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected register state queued per step, checked after each edge.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [MASK_W-1:0] stall0, stall1, nop0, nop1;
    logic              flush0, flush1, branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic [31:0]       fetch_instr0, fetch_instr1;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       if_id_instr0, if_id_instr1;
    logic              if_id_valid0, if_id_valid1, id_ex_bubble0, id_ex_bubble1, first;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]       stall_cycles;
`endif

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic              v0, v1;
        logic [31:0]       i0, i1;
        bit                chk_i0;
        logic              first;
        logic [31:0]       cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    pipe_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .stall0        (stall0),
        .stall1        (stall1),
        .nop0          (nop0),
        .nop1          (nop1),
        .flush0        (flush0),
        .flush1        (flush1),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .fetch_instr0  (fetch_instr0),
        .fetch_instr1  (fetch_instr1),
        .pc            (pc),
        .if_id_instr0  (if_id_instr0),
        .if_id_instr1  (if_id_instr1),
        .if_id_valid0  (if_id_valid0),
        .if_id_valid1  (if_id_valid1),
        .id_ex_bubble0 (id_ex_bubble0),
        .id_ex_bubble1 (id_ex_bubble1),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cycles  (stall_cycles),
`endif
        .first         (first)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic br, input logic [ADDR_W-1:0] tgt,
                         input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] n0,
                         input logic [3:0] n1, input logic f0, input logic f1, input int n);
        @(negedge clk);
        reset = rst; branch_taken = br; branch_target = tgt;
        stall0 = MASK_W'(s0); stall1 = MASK_W'(s1); nop0 = MASK_W'(n0); nop1 = MASK_W'(n1);
        flush0 = f0; flush1 = f1;
        fetch_instr0 = 32'hA000_0000 + 32'(n);
        fetch_instr1 = 32'hB000_0000 + 32'(n);
    endtask

    task automatic bub(input string tag, input logic b0, input logic b1);
        #1;
        chk({tag, ".bubble0"}, 64'(id_ex_bubble0), 64'(b0));
        chk({tag, ".bubble1"}, 64'(id_ex_bubble1), 64'(b1));
    endtask

    task automatic push(input logic [ADDR_W-1:0] p, input logic v0, input logic v1,
                        input logic [31:0] i0, input logic [31:0] i1, input bit ci0,
                        input logic f, input logic [31:0] cyc);
        exp_t e;
        e.pc = p; e.v0 = v0; e.v1 = v1; e.i0 = i0; e.i1 = i1;
        e.chk_i0 = ci0; e.first = f; e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, ".pc"},     64'(pc),           64'(e.pc));
            chk({tag, ".valid0"}, 64'(if_id_valid0), 64'(e.v0));
            chk({tag, ".valid1"}, 64'(if_id_valid1), 64'(e.v1));
            if (e.chk_i0)
                chk({tag, ".instr0"}, 64'(if_id_instr0), 64'(e.i0));
            chk({tag, ".instr1"}, 64'(if_id_instr1), 64'(e.i1));
            chk({tag, ".first"},  64'(first),        64'(e.first));
`ifdef PIPE_CTRL_PERF_EN
            chk({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(e.cyc));
`endif
        end
    endtask

    initial begin
        reset = 1'b1; branch_taken = 1'b0; branch_target = '0;
        stall0 = '0; stall1 = '0; nop0 = '0; nop1 = '0; flush0 = 1'b0; flush1 = 1'b0;
        fetch_instr0 = '0; fetch_instr1 = '0;

        // reset together with branch and stall
        drive(1, 1, 8'h33, 4'hF, 4'hF, 0, 0, 1, 1, 0); bub("rst", 1, 1);
        push(8'h00, 0, 0, NOP, NOP, 1, 1, 0); tick("rst");

        // idle pair loads
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); bub("idle1", 1, 1);
        push(8'h02, 1, 1, 32'hA000_0001, 32'hB000_0001, 1, 1, 0); tick("idle1");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2); bub("idle2", 0, 0);
        push(8'h04, 1, 1, 32'hA000_0002, 32'hB000_0002, 1, 1, 0); tick("idle2");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3); bub("idle3", 0, 0);
        push(8'h06, 1, 1, 32'hA000_0003, 32'hB000_0003, 1, 1, 0); tick("idle3");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4); bub("idle4", 0, 0);
        push(8'h08, 1, 1, 32'hA000_0004, 32'hB000_0004, 1, 1, 0); tick("idle4");

        // lane0 stall PC|IF_ID|ID_EX with nop0 ID_EX
        drive(0, 0, 0, 4'b0111, 0, 4'b0100, 0, 0, 0, 5); bub("stall0", 1, 0);
        push(8'h08, 1, 1, 32'hA000_0004, 32'hB000_0005, 1, 1, 1); tick("stall0");

        // flush1 with stall1 on PC
        drive(0, 0, 0, 0, 4'b0001, 0, 0, 0, 1, 6); bub("flush1", 0, 0);
        push(8'h08, 1, 0, 32'hA000_0006, NOP, 1, 1, 2); tick("flush1");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 7); bub("after_flush", 0, 1);
        push(8'h0A, 1, 1, 32'hA000_0007, 32'hB000_0007, 1, 1, 2); tick("after_flush");

        // branch to odd target during an active stall
        drive(0, 1, 8'h15, 4'b0011, 4'b0010, 0, 0, 0, 0, 8); bub("branch", 1, 1);
        push(8'h15, 0, 0, NOP, NOP, 1, 0, 2); tick("branch");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 9); bub("redirect_load", 1, 1);
        push(8'h17, 0, 1, 32'h0, 32'hB000_0009, 0, 0, 2); tick("redirect_load");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 10); bub("post_redirect", 1, 0);
        push(8'h19, 1, 1, 32'hA000_000A, 32'hB000_000A, 1, 0, 2); tick("post_redirect");

        // both flushes at once
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 11); bub("flush_both", 0, 0);
        push(8'h1B, 0, 0, NOP, NOP, 1, 0, 2); tick("flush_both");

        // pc wrap
        drive(0, 1, 8'hFE, 0, 0, 0, 0, 0, 0, 12); bub("br_top", 1, 1);
        push(8'hFE, 0, 0, NOP, NOP, 1, 1, 2); tick("br_top");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 13); bub("wrap", 1, 1);
        push(8'h00, 1, 1, 32'hA000_000D, 32'hB000_000D, 1, 1, 2); tick("wrap");

        // reset concurrent with branch clears counter, then first pair load
        drive(1, 1, 8'h33, 4'b0001, 0, 0, 0, 0, 0, 14); bub("rst_br", 1, 1);
        push(8'h00, 0, 0, NOP, NOP, 1, 1, 0); tick("rst_br");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 15); bub("post_rst", 1, 1);
        push(8'h02, 1, 1, 32'hA000_000F, 32'hB000_000F, 1, 1, 0); tick("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
